// File: rtl/vector_register_file_mp_pkg.sv
// Shared types for the SIMT vector register file: default geometry, word/index types
// and the clear-sweep state encoding.
package vector_register_file_mp_pkg;

   localparam int unsigned THREADS_DEF    = 4;
   localparam int unsigned REGS_DEF       = 32;
   localparam int unsigned READ_PORTS_DEF = 2;
   localparam int unsigned WORD_W_DEF     = 32;

   typedef logic [WORD_W_DEF-1:0]        word_t;
   typedef logic [$clog2(REGS_DEF)-1:0]  regbits_t;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StDone
   } vrf_state_t;

endpackage

// File: rtl/vector_register_file_mp_if.sv
// Bus between decode/writeback and the vector register file; lane data is packed,
// lane t at [t*WORD_W +: WORD_W], read port p lane t at [(p*THREADS+t)*WORD_W +: WORD_W].
interface vector_register_file_if
   import vector_register_file_mp_pkg::*;
#(
   parameter int unsigned THREADS    = THREADS_DEF,
   parameter int unsigned REGS       = REGS_DEF,
   parameter int unsigned READ_PORTS = READ_PORTS_DEF,
   parameter int unsigned WORD_W     = WORD_W_DEF
);
   localparam int unsigned AW = $clog2(REGS);

   logic [THREADS-1:0]                   wen;
   logic                                 wbcast;
   logic [AW-1:0]                        wsel;
   logic [THREADS*WORD_W-1:0]            wdata;
   logic [WORD_W-1:0]                    wscalar;
   logic                                 wready;
   logic [READ_PORTS*AW-1:0]             rsel;
   logic [READ_PORTS*THREADS*WORD_W-1:0] rdata;
   logic                                 clr_req;
   logic                                 clr_busy;
   logic                                 clr_done;

   modport master (
      output wen, wbcast, wsel, wdata, wscalar, rsel, clr_req,
      input  wready, rdata, clr_busy, clr_done
   );

   modport slave (
      input  wen, wbcast, wsel, wdata, wscalar, rsel, clr_req,
      output wready, rdata, clr_busy, clr_done
   );

endinterface

// File: rtl/vector_register_file_mp_lane_bank.sv
// One lane's register storage: single write port, READ_PORTS asynchronous reads and
// a clear port used by the sweep. Register 0 is never written.
module vrf_lane_bank #(
   parameter int unsigned REGS       = 32,
   parameter int unsigned READ_PORTS = 2,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned AW         = $clog2(REGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [AW-1:0]                waddr,
   input  logic [WORD_W-1:0]            wdata,
   input  logic                         clr_en,
   input  logic [AW-1:0]                clr_idx,
   input  logic [READ_PORTS*AW-1:0]     raddr,
   output logic [READ_PORTS*WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(REGS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_en) begin
         mem_q[clr_idx] <= '0;
      end else if (we && (waddr != '0)) begin
         mem_q[waddr] <= wdata;
      end
   end

   for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_rd
      assign rdata[p*WORD_W +: WORD_W] = mem_q[raddr[p*AW +: AW]];
   end

endmodule

// File: rtl/vector_register_file_mp.sv
// Multi-port, lane-masked vector register file with broadcast writes, write-to-read
// bypass and a hardware clear sweep that zero-fills one register per cycle.
module vector_register_file_mp
   import vector_register_file_mp_pkg::*;
#(
   parameter int unsigned THREADS    = THREADS_DEF,
   parameter int unsigned REGS       = REGS_DEF,
   parameter int unsigned READ_PORTS = READ_PORTS_DEF,
   parameter int unsigned WORD_W     = WORD_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   vector_register_file_if.slave   bus
);

   localparam int unsigned AW = $clog2(REGS);
   localparam logic [AW-1:0] LAST_IDX = AW'(REGS - 1);

   vrf_state_t    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          wready, clr_en, clr_busy, clr_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wready   = 1'b0;
      clr_en   = 1'b0;
      clr_busy = 1'b0;
      clr_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            wready = 1'b1;
            if (bus.clr_req) begin
               state_d = StSweep;
               cnt_d   = AW'(1);
            end
         end
         StSweep: begin
            clr_en   = 1'b1;
            clr_busy = 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            clr_done = 1'b1;
            state_d  = StIdle;
            cnt_d    = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.wready   = wready;
   assign bus.clr_busy = clr_busy;
   assign bus.clr_done = clr_done;

   for (genvar t = 0; t < int'(THREADS); t++) begin : g_lane
      logic [WORD_W-1:0]            wval;
      logic                         we;
      logic [READ_PORTS*WORD_W-1:0] bank_rd;

      assign wval = bus.wbcast ? bus.wscalar : bus.wdata[t*WORD_W +: WORD_W];
      // Gating with wready drops writes (and their bypass) while the sweep owns the array.
      assign we   = wready & bus.wen[t];

      vrf_lane_bank #(
         .REGS       (REGS),
         .READ_PORTS (READ_PORTS),
         .WORD_W     (WORD_W),
         .AW         (AW)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we      (we),
         .waddr   (bus.wsel),
         .wdata   (wval),
         .clr_en  (clr_en),
         .clr_idx (cnt_q),
         .raddr   (bus.rsel),
         .rdata   (bank_rd)
      );

      for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_port
         logic [AW-1:0]     idx;
         logic [WORD_W-1:0] rd;

         assign idx = bus.rsel[p*AW +: AW];

         always_comb begin
            if (idx == '0) begin
               rd = '0;
            end else if (we && (bus.wsel == idx)) begin
               rd = wval;
            end else begin
               rd = bank_rd[p*WORD_W +: WORD_W];
            end
         end

         assign bus.rdata[(p*THREADS+t)*WORD_W +: WORD_W] = rd;
      end
   end

endmodule

// File: tb/tb_vector_register_file_mp.sv
// Randomised and directed bench for vector_register_file_mp against a behavioural
// array model of the register file and its clear sweep.
module tb_vector_register_file_mp;
   localparam int THREADS = 4;
   localparam int REGS = 32;
   localparam int READ_PORTS = 2;
   localparam int WORD_W = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vector_register_file_if #(
      .THREADS(THREADS), .REGS(REGS), .READ_PORTS(READ_PORTS), .WORD_W(WORD_W)
   ) vif ();

   vector_register_file_mp #(
      .THREADS(THREADS), .REGS(REGS), .READ_PORTS(READ_PORTS), .WORD_W(WORD_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: array contents plus "registers still to clear" for an active sweep.
   logic [WORD_W-1:0] model [THREADS][REGS];
   int sweep_next;    // next register index to clear; 0 when no sweep in progress
   bit done_cycle;    // the cycle right after the last register was cleared

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_idle();
      return (sweep_next == 0) && !done_cycle;
   endfunction

   function automatic logic [WORD_W-1:0] m_wval(int t);
      return vif.wbcast ? vif.wscalar : vif.wdata[t*WORD_W +: WORD_W];
   endfunction

   function automatic logic [WORD_W-1:0] m_read(int p, int t);
      int idx;
      idx = int'(vif.rsel[p*AW +: AW]);
      if (idx == 0) return '0;
      if (m_idle() && vif.wen[t] && int'(vif.wsel) == idx) return m_wval(t);
      return model[t][idx];
   endfunction

   task automatic m_reset();
      foreach (model[t, r]) model[t][r] = '0;
      sweep_next = 0;
      done_cycle = 1'b0;
   endtask

   task automatic m_clock();
      if (done_cycle) begin
         done_cycle = 1'b0;
      end else if (sweep_next != 0) begin
         for (int t = 0; t < THREADS; t++) model[t][sweep_next] = '0;
         if (sweep_next == REGS - 1) begin
            sweep_next = 0;
            done_cycle = 1'b1;
         end else begin
            sweep_next++;
         end
      end else begin
         for (int t = 0; t < THREADS; t++)
            if (vif.wen[t] && vif.wsel != 0) model[t][vif.wsel] = m_wval(t);
         if (vif.clr_req) sweep_next = 1;
      end
   endtask

   task automatic check_all(string tag);
      for (int p = 0; p < READ_PORTS; p++)
         for (int t = 0; t < THREADS; t++)
            check($sformatf("%s rdata p%0d t%0d", tag, p, t),
                  vif.rdata[(p*THREADS+t)*WORD_W +: WORD_W], m_read(p, t));
      check({tag, " wready"}, 32'(vif.wready), 32'(m_idle()));
      check({tag, " clr_busy"}, 32'(vif.clr_busy), 32'(sweep_next != 0));
      check({tag, " clr_done"}, 32'(vif.clr_done), 32'(done_cycle));
   endtask

   // Inputs are set at the falling edge; check, advance model, clock, return at next fall.
   task automatic step(string tag);
      #1;
      check_all(tag);
      m_clock();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      vif.wen = '0; vif.wbcast = 1'b0; vif.wsel = '0; vif.wdata = '0;
      vif.wscalar = '0; vif.rsel = '0; vif.clr_req = 1'b0;
   endtask

   task automatic rand_inputs(bit allow_clr);
      vif.wen     = 4'($urandom);
      vif.wbcast  = ($urandom_range(0, 3) == 0);
      vif.wsel    = 5'($urandom);
      vif.wdata   = {$urandom, $urandom, $urandom, $urandom};
      vif.wscalar = $urandom;
      vif.rsel    = 10'($urandom);
      if ($urandom_range(0, 2) == 0) vif.rsel[0 +: AW] = vif.wsel;
      vif.clr_req = allow_clr && ($urandom_range(0, 49) == 0);
   endtask

   task automatic read_all(string tag);
      idle_inputs();
      for (int r = 0; r < REGS; r++) begin
         vif.rsel = {5'(REGS - 1 - r), 5'(r)};
         step(tag);
      end
   endtask

   task automatic fill_all();
      for (int r = 1; r < REGS; r++) begin
         rand_inputs(1'b0);
         vif.wen = 4'hf;
         vif.wsel = 5'(r);
         step("fill");
      end
   endtask

   initial begin
      int n_busy, n_done, guard;
      idle_inputs();
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset contents and flags.
      read_all("reset");

      // Lane-masked write.
      vif.wen = 4'b0101; vif.wsel = 5'd5;
      vif.wdata = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      step("mask wr");
      idle_inputs();
      vif.rsel = {5'd5, 5'd5};
      #1;
      check("mask lane0", vif.rdata[0 +: 32], 32'hAAAA_0000);
      check("mask lane1", vif.rdata[32 +: 32], 32'h0);
      check("mask lane2", vif.rdata[64 +: 32], 32'hCCCC_0002);
      check("mask lane3", vif.rdata[96 +: 32], 32'h0);
      step("mask rd");

      // Broadcast write with same-cycle bypass.
      vif.wen = 4'hf; vif.wbcast = 1'b1; vif.wsel = 5'd7; vif.wscalar = 32'hDEADBEEF;
      vif.rsel = {5'd3, 5'd7};
      #1;
      for (int t = 0; t < THREADS; t++)
         check($sformatf("bypass lane%0d", t), vif.rdata[t*32 +: 32], 32'hDEADBEEF);
      step("bcast");

      // Writes to r0 are discarded.
      idle_inputs();
      vif.wen = 4'hf; vif.wbcast = 1'b1; vif.wsel = 5'd0; vif.wscalar = 32'h1234;
      step("r0 wr");
      idle_inputs();
      step("r0 rd");

      // Full fill, then a sweep with writes offered throughout.
      fill_all();
      idle_inputs();
      vif.clr_req = 1'b1;
      step("clr req");
      n_busy = vif.clr_busy ? 1 : 0;
      n_done = 0;
      guard = 0;
      while ((vif.clr_busy || vif.clr_done) && guard < 60) begin
         rand_inputs(1'b0);
         step("sweep");
         n_busy += vif.clr_busy ? 1 : 0;
         n_done += vif.clr_done ? 1 : 0;
         guard++;
      end
      check("sweep busy cycles", 32'(n_busy), 32'd31);
      check("sweep done pulses", 32'(n_done), 32'd1);
      read_all("post sweep");

      // Reset in the middle of a sweep.
      fill_all();
      idle_inputs();
      vif.clr_req = 1'b1;
      step("clr req2");
      idle_inputs();
      for (int i = 0; i < 9; i++) step("sweep2");
      rst = 1'b1;
      m_reset();
      #1;
      check_all("mid rst");
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int i = 0; i < 25; i++) begin
         step("after rst");
         n_done += vif.clr_done ? 1 : 0;
      end
      check("no done after abort", 32'(n_done), 32'd0);
      vif.wen = 4'hf; vif.wsel = 5'd3; vif.wdata = {4{32'h0BAD_CAFE}};
      step("r3 wr");
      idle_inputs();
      vif.rsel = {5'd3, 5'd3};
      step("r3 rd");

      // Random traffic including occasional sweeps.
      for (int i = 0; i < 500; i++) begin
         rand_inputs(1'b1);
         step("rand");
      end
      read_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
